// File: rtl/mul_share_pkg.sv
// rtl/mul_share_pkg.sv - shared widths and helpers for the shared-multiplier arbiter
// Holds default operand/product widths, the statistics counter width and
// the requester-index width function used by mul_share_arbiter.
package mul_share_pkg;

  localparam int DEF_DIN0_W = 10;
  localparam int DEF_DIN1_W = 10;
  localparam int DEF_DOUT_W = 20;
  localparam int STAT_W     = 32;

  // Index width for n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mul_share_core.sv
// rtl/mul_share_core.sv - combinational unsigned x signed multiplier
// Ports:
//   din0  in  DIN0_W  unsigned operand
//   din1  in  DIN1_W  signed operand (two's complement)
//   dout  out DOUT_W  signed full-precision product
module mul_share_core #(
  parameter int DIN0_W = 10,
  parameter int DIN1_W = 10,
  parameter int DOUT_W = 20
) (
  input  logic [DIN0_W-1:0] din0,
  input  logic [DIN1_W-1:0] din1,
  output logic [DOUT_W-1:0] dout
);

  // Both operands extended to the product width so the signed multiply
  // is exact: din0 zero-extended, din1 sign-extended.
  logic signed [DOUT_W-1:0] a_ext;
  logic signed [DOUT_W-1:0] b_ext;

  assign a_ext = $signed({{(DOUT_W-DIN0_W){1'b0}}, din0});
  assign b_ext = $signed({{(DOUT_W-DIN1_W){din1[DIN1_W-1]}}, din1});
  assign dout  = a_ext * b_ext;

endmodule

// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin arbiter sharing one multiplier among requesters
// Optional statistics counters are enabled by defining MUL_SHARE_ARB_STATS_EN.
// Ports:
//   ap_clk, ap_rst        clock, synchronous active-high reset
//   req_valid/req_ready   per-requester handshake (ready one-hot or zero)
//   req_din0/req_din1     packed operands, requester i at [i*W +: W]
//   out_valid/out_ready   registered result handshake
//   out_id, out_dout      owning requester index and signed product
//   stat_grants/stalls    (MUL_SHARE_ARB_STATS_EN only) fire and stall cycle counts
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DIN0_W  = DEF_DIN0_W,
  parameter int DIN1_W  = DEF_DIN1_W,
  parameter int DOUT_W  = DEF_DOUT_W,
  localparam int ID_W   = id_width(NUM_REQ)
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DIN0_W-1:0] req_din0,
  input  logic [NUM_REQ*DIN1_W-1:0] req_din1,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ID_W-1:0]           out_id,
  output logic [DOUT_W-1:0]         out_dout
`ifdef MUL_SHARE_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]         stat_grants,
  output logic [STAT_W-1:0]         stat_stalls
`endif
);

  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   ptr_next;
  logic              found;
  logic              can_accept;
  logic              fire;
  logic [DIN0_W-1:0] sel_din0;
  logic [DIN1_W-1:0] sel_din1;
  logic [DOUT_W-1:0] product;

  assign can_accept = !out_valid || out_ready;
  assign fire       = (|req_valid) && can_accept && !ap_rst;

  // Cyclic search starting at ptr; the index is formed one bit wider so the
  // wrap works for requester counts that are not a power of two.
  always_comb begin
    logic [ID_W:0] sum;
    grant = '0;
    found = 1'b0;
    sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ)) begin
        sum = sum - (ID_W+1)'(NUM_REQ);
      end
      if (!found && req_valid[sum[ID_W-1:0]]) begin
        grant = sum[ID_W-1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (fire) begin
      req_ready[grant] = 1'b1;
    end
  end

  assign ptr_next = (grant == ID_W'(NUM_REQ-1)) ? '0 : grant + 1'b1;

  assign sel_din0 = req_din0[grant*DIN0_W +: DIN0_W];
  assign sel_din1 = req_din1[grant*DIN1_W +: DIN1_W];

  mul_share_core #(
    .DIN0_W(DIN0_W),
    .DIN1_W(DIN1_W),
    .DOUT_W(DOUT_W)
  ) u_core (
    .din0(sel_din0),
    .din1(sel_din1),
    .dout(product)
  );

  // A fire while out_valid && out_ready replaces the old result in place,
  // giving one result per cycle with no bubble.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      out_valid <= 1'b0;
      out_id    <= '0;
      out_dout  <= '0;
      ptr       <= '0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_id    <= grant;
      out_dout  <= product;
      ptr       <= ptr_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUL_SHARE_ARB_STATS_EN
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      stat_grants <= '0;
      stat_stalls <= '0;
    end else begin
      if (fire) begin
        stat_grants <= stat_grants + STAT_W'(1);
      end
      if ((|req_valid) && !can_accept) begin
        stat_stalls <= stat_stalls + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - self-checking bench for mul_share_arbiter
module tb_mul_share_arbiter;

  localparam int N  = 4;
  localparam int W0 = 10;
  localparam int W1 = 10;
  localparam int WO = 20;
  localparam int IW = 2;

  logic            ap_clk = 1'b0;
  logic            ap_rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W0-1:0] req_din0;
  logic [N*W1-1:0] req_din1;
  logic            out_valid;
  logic            out_ready;
  logic [IW-1:0]   out_id;
  logic [WO-1:0]   out_dout;
`ifdef MUL_SHARE_ARB_STATS_EN
  logic [31:0]     stat_grants;
  logic [31:0]     stat_stalls;
`endif

  logic [W0-1:0] d0 [N];
  logic [W1-1:0] d1 [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_din0[i*W0 +: W0] = d0[i];
      req_din1[i*W1 +: W1] = d1[i];
    end
  end

  always #5 ap_clk = ~ap_clk;

  mul_share_arbiter #(
    .NUM_REQ(N), .DIN0_W(W0), .DIN1_W(W1), .DOUT_W(WO)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_din0(req_din0),
    .req_din1(req_din1),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_id(out_id),
    .out_dout(out_dout)
`ifdef MUL_SHARE_ARB_STATS_EN
    ,
    .stat_grants(stat_grants),
    .stat_stalls(stat_stalls)
`endif
  );

  // Reference model state
  int          m_valid;
  int          m_id;
  int          m_ptr;
  logic [WO-1:0] m_dout;
  logic [31:0] m_grants;
  logic [31:0] m_stalls;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int pick();
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (req_valid[idx[IW-1:0]]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [WO-1:0] prod(input int i);
    int a;
    int b;
    logic [31:0] r;
    a = int'(d0[i]);
    b = int'($signed(d1[i]));
    r = a * b;
    return r[WO-1:0];
  endfunction

  task automatic cycle(input string tag);
    int            g;
    logic          fire;
    logic          stall;
    logic [WO-1:0] p;
    #2;
    g     = pick();
    fire  = (g >= 0) && (m_valid == 0 || out_ready) && !ap_rst;
    stall = (req_valid != 0) && !(m_valid == 0 || out_ready);
    p     = (g >= 0) ? prod(g) : '0;
    chk({tag, ".ready"}, 32'(req_ready), fire ? (32'd1 << g) : 32'd0);
    @(posedge ap_clk);
    #1;
    if (ap_rst) begin
      m_valid = 0; m_id = 0; m_dout = '0; m_ptr = 0;
      m_grants = '0; m_stalls = '0;
    end else begin
      if (fire) begin
        m_valid = 1; m_id = g; m_dout = p; m_ptr = (g + 1) % N;
      end else if (out_ready) begin
        m_valid = 0;
      end
      if (fire)  m_grants = m_grants + 1;
      if (stall) m_stalls = m_stalls + 1;
    end
    chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".id"},    32'(out_id),    32'(m_id));
    chk({tag, ".dout"},  32'(out_dout),  32'(m_dout));
`ifdef MUL_SHARE_ARB_STATS_EN
    chk({tag, ".grants"}, stat_grants, m_grants);
    chk({tag, ".stalls"}, stat_stalls, m_stalls);
`endif
  endtask

  int rr_ids[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    m_valid = 0; m_id = 0; m_ptr = 0; m_dout = '0;
    m_grants = '0; m_stalls = '0;
    ap_rst    = 1'b1;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      d0[i] = W0'(i + 5);
      d1[i] = W1'(i + 7);
    end

    // Reset held two cycles with all requesters valid
    cycle("reset0");
    cycle("reset1");
    chk("reset.valid", 32'(out_valid), 32'd0);

    // First grant after release goes to requester 0
    ap_rst = 1'b0;
    cycle("first");
    chk("first.id", 32'(out_id), 32'd0);
    req_valid = 4'b0000;
    cycle("drain0");

    // Single request from requester 2
    d0[2] = 10'd1023;
    d1[2] = 10'h200;
    req_valid = 4'b0100;
    cycle("single");
    chk("single.id",   32'(out_id),   32'd2);
    chk("single.dout", 32'(out_dout), 32'h80200);
    req_valid = 4'b0000;
    cycle("drain1");

    // Move pointer back to 0, then continuous round-robin
    req_valid = 4'b1000;
    cycle("align");
    for (int i = 0; i < N; i++) begin
      d0[i] = W0'(i + 1);
      d1[i] = W1'(-(i + 1));
    end
    req_valid = 4'b1111;
    for (int s = 0; s < 6; s++) begin
      cycle("rr");
      chk("rr.id", 32'(out_id), 32'(rr_ids[s]));
      chk("rr.valid", 32'(out_valid), 32'd1);
    end
    chk("rr.dout_last", 32'(out_dout), 32'hFFFFC);

    // Back-pressure with requesters 1 and 3 valid, then release
    out_ready = 1'b0;
    req_valid = 4'b1010;
    for (int s = 0; s < 3; s++) begin
      cycle("bp");
      chk("bp.id", 32'(out_id), 32'd1);
    end
    out_ready = 1'b1;
    cycle("bp_release");
    chk("bp_release.id", 32'(out_id), 32'd3);

    // Pointer skip: get ptr to 1, then only requester 0 valid
    req_valid = 4'b0001;
    cycle("skip_set");
    cycle("skip");
    chk("skip.id", 32'(out_id), 32'd0);
    req_valid = 4'b0011;
    cycle("skip_ptr");
    chk("skip_ptr.id", 32'(out_id), 32'd1);

    // Reset while a result is held under back-pressure
    out_ready = 1'b0;
    ap_rst    = 1'b1;
    cycle("midrst");
    chk("midrst.valid", 32'(out_valid), 32'd0);
    ap_rst = 1'b0;

    // Randomized traffic against the model
    for (int s = 0; s < 400; s++) begin
      ap_rst    = ($urandom_range(0, 49) == 0);
      req_valid = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        d0[i] = W0'($urandom);
        d1[i] = W1'($urandom);
      end
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
